scancode_to_uart: RTL and testbench
===================================

SCANCODE_TO_UART -- requirements
Module: scancode_to_uart

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of queued ASCII bytes awaiting transmission (power of two, 2..16).
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 scancode  input  8  PS/2 Set-2 byte from the keyboard receiver.
REQ-005 new_code  input  1  one-cycle strobe; scancode is valid in the same cycle.
REQ-006 tx_busy  input  1  UART transmitter busy flag.
REQ-007 tx_data  output  8  byte presented to the UART transmitter.
REQ-008 tx_en  output  1  one-cycle send strobe to the UART transmitter.
REQ-009 last_ascii  output  8  most recent translated character, for display or LEDs.
REQ-010 key_strobe  output  1  one-cycle pulse when last_ascii updates.
REQ-011 overflow  output  1  sticky flag; set when a character is dropped because the FIFO is full.

Function
REQ-012 The decoder FSM SHALL have four states: IDLE, BREAK, EXT and EXT_BREAK, and SHALL advance only on cycles where new_code=1.
REQ-013 In IDLE, the decoder SHALL handle each scancode as follows.
- 0xF0 -> BREAK.
- 0xE0 -> EXT.
- Any other byte -> table lookup, staying in IDLE.
REQ-014 In BREAK, 0xF0 SHALL keep the state in BREAK, and any other byte SHALL be discarded with a return to IDLE.
REQ-015 In EXT, 0xF0 SHALL go to EXT_BREAK, and any other byte SHALL be discarded with a return to IDLE; extended keys never produce output.
REQ-016 In EXT_BREAK, any byte SHALL be discarded with a return to IDLE.
REQ-017 The lookup SHALL map make codes as follows; all other codes SHALL be silently ignored.
- a-z -> lowercase ASCII.
- 0-9 (main row) -> ASCII digits.
- 0x29 -> 0x20 (space).
- 0x5A -> 0x0D (enter).
- 0x66 -> 0x08 (backspace).
REQ-018 A translated character SHALL be registered into the FIFO, last_ascii and key_strobe one cycle after its new_code.
REQ-019 If the FIFO is full at write time and no pop occurs in the same cycle, the character SHALL be dropped, overflow SHALL be set, and last_ascii/key_strobe SHALL still update.
REQ-020 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; occupancy is then unchanged.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate occupancy count distinguishing full from empty.
REQ-022 The transmit FSM SHALL have three states: TX_IDLE, TX_HOLD and TX_WAIT.
REQ-023 In TX_IDLE, when the FIFO is non-empty and tx_busy=0, the FSM SHALL perform the following in one cycle.
- Drive tx_data = FIFO head.
- Pulse tx_en for that single cycle.
- Pop the FIFO.
- Enter TX_HOLD.
REQ-024 TX_HOLD SHALL last exactly 2 cycles regardless of tx_busy, then enter TX_WAIT; this covers transmitter busy-assert latency.
REQ-025 TX_WAIT SHALL return to TX_IDLE on the first cycle tx_busy=0.
REQ-026 tx_data SHALL hold its value from the tx_en cycle until the next tx_en.
REQ-027 Best-case latency SHALL be 2 cycles from new_code to tx_en: FIFO write at N+1, tx_en at N+2.
REQ-028 Characters SHALL be transmitted in arrival order with no duplication.

Reset
REQ-029 On reset, outputs SHALL take these values: tx_en=0, tx_data=0x00, last_ascii=0x00, key_strobe=0, overflow=0.
REQ-030 On reset, the FIFO SHALL be emptied and both FSMs SHALL return to IDLE/TX_IDLE.
REQ-031 Reset asserted mid-transmission or mid-sequence (e.g. after 0xF0) SHALL discard all pending state; the next byte after release is decoded from IDLE.

Structure
REQ-032 A shared package SHALL hold the following.
- Decoder and transmit state encodings.
- Constants for the break (0xF0) and extended (0xE0) prefixes.
- The scancode-to-ASCII lookup function.
REQ-033 The FIFO SHALL be a single sub-module, sync_fifo, parameterised by width and depth, with push/pop/full/empty/count.

Verification
REQ-034 Scenario: press and release "a" (0x1C, 0xF0, 0x1C) with tx_busy=0 -> exactly one tx_en with tx_data=0x61, 2 cycles after the first new_code; last_ascii=0x61.
REQ-035 Scenario: extended sequence 0xE0 0x75, 0xE0 0xF0 0x75 -> no tx_en and no key_strobe; decoder ends in IDLE.
REQ-036 Scenario: hold tx_busy=1 and send 6 make codes (h, e, l, l, o, space) with FIFO_DEPTH=4 -> overflow=1; after tx_busy is released, only 0x68 0x65 0x6C 0x6C are sent, in order.
REQ-037 Scenario: FIFO full, tx_busy drops, and a new make code 0x16 arrives in the pop cycle -> pop and push both succeed, and 0x31 is sent last.
REQ-038 Scenario: assert reset one cycle after 0xF0, then send 0x1B -> tx_data=0x73 is sent; overflow=0.
REQ-039 Scenario: 0x5A and 0x66 make codes -> 0x0D then 0x08; unmapped 0x76 -> no output.

Source files
------------

// File: rtl/scancode_to_uart_pkg.sv
// Shared types, prefix constants and the PS/2 Set-2 make-code to ASCII table
// for the keyboard-to-UART bridge.
package scancode_to_uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } dec_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HOLD = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef struct packed {
    logic       valid;
    logic [7:0] ascii;
  } ascii_lookup_t;

  // Unmapped codes come back with valid=0 so the caller can drop them silently.
  function automatic ascii_lookup_t sc_lookup(input logic [7:0] sc);
    ascii_lookup_t r;
    r.valid = 1'b1;
    r.ascii = 8'h00;
    case (sc)
      8'h1C: r.ascii = 8'h61; // a
      8'h32: r.ascii = 8'h62;
      8'h21: r.ascii = 8'h63;
      8'h23: r.ascii = 8'h64;
      8'h24: r.ascii = 8'h65;
      8'h2B: r.ascii = 8'h66;
      8'h34: r.ascii = 8'h67;
      8'h33: r.ascii = 8'h68;
      8'h43: r.ascii = 8'h69;
      8'h3B: r.ascii = 8'h6A;
      8'h42: r.ascii = 8'h6B;
      8'h4B: r.ascii = 8'h6C;
      8'h3A: r.ascii = 8'h6D;
      8'h31: r.ascii = 8'h6E;
      8'h44: r.ascii = 8'h6F;
      8'h4D: r.ascii = 8'h70;
      8'h15: r.ascii = 8'h71;
      8'h2D: r.ascii = 8'h72;
      8'h1B: r.ascii = 8'h73;
      8'h2C: r.ascii = 8'h74;
      8'h3C: r.ascii = 8'h75;
      8'h2A: r.ascii = 8'h76;
      8'h1D: r.ascii = 8'h77;
      8'h22: r.ascii = 8'h78;
      8'h35: r.ascii = 8'h79;
      8'h1A: r.ascii = 8'h7A; // z
      8'h45: r.ascii = 8'h30; // 0
      8'h16: r.ascii = 8'h31;
      8'h1E: r.ascii = 8'h32;
      8'h26: r.ascii = 8'h33;
      8'h25: r.ascii = 8'h34;
      8'h2E: r.ascii = 8'h35;
      8'h36: r.ascii = 8'h36;
      8'h3D: r.ascii = 8'h37;
      8'h3E: r.ascii = 8'h38;
      8'h46: r.ascii = 8'h39; // 9
      8'h29: r.ascii = 8'h20; // space
      8'h5A: r.ascii = 8'h0D; // enter
      8'h66: r.ascii = 8'h08; // backspace
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; power-of-two depth so pointers wrap for free, with a
// separate occupancy count to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the slot the push needs, so push+pop is legal even when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scancode_to_uart.sv
// PS/2 Set-2 scancode decoder feeding a byte FIFO that drains into a UART
// transmitter with a fixed post-send hold to ride out busy-assert latency.
module scancode_to_uart
  import scancode_to_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       new_code,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic [7:0] last_ascii,
  output logic       key_strobe,
  output logic       overflow
);
  dec_state_t    dec_state, dec_next;
  tx_state_t     tx_state, tx_next;
  ascii_lookup_t lk;
  logic          char_vld, launch, hold_cnt;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  assign lk = sc_lookup(scancode);

  // Only a bare make code in IDLE yields a character; every prefixed byte is eaten.
  always_comb begin
    dec_next = dec_state;
    char_vld = 1'b0;
    if (new_code) begin
      case (dec_state)
        IDLE: begin
          if (scancode == BREAK_CODE)    dec_next = BREAK;
          else if (scancode == EXT_CODE) dec_next = EXT;
          else                           char_vld = lk.valid;
        end
        BREAK:     if (scancode != BREAK_CODE) dec_next = IDLE;
        EXT:       dec_next = (scancode == BREAK_CODE) ? EXT_BREAK : IDLE;
        EXT_BREAK: dec_next = IDLE;
        default:   dec_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_state  <= IDLE;
      last_ascii <= 8'h00;
      key_strobe <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dec_state  <= dec_next;
      key_strobe <= char_vld;
      if (char_vld) last_ascii <= lk.ascii;
      if (char_vld && fifo_full && !launch) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (char_vld),
    .pop   (launch),
    .din   (lk.ascii),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  always_comb begin
    tx_next = tx_state;
    launch  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          launch  = 1'b1;
          tx_next = TX_HOLD;
        end
      end
      TX_HOLD: if (hold_cnt) tx_next = TX_WAIT;
      TX_WAIT: if (!tx_busy) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // tx_data only moves on a launch, so it stays stable between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      hold_cnt <= 1'b0;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_state <= tx_next;
      hold_cnt <= (tx_state == TX_HOLD) ? ~hold_cnt : 1'b0;
      tx_en    <= launch;
      if (launch) tx_data <= fifo_head;
    end
  end

endmodule

// File: tb/tb_scancode_to_uart.sv
// Directed bench: queue-based character model checked every cycle, plus
// hand-computed expectations for each keyboard scenario.
module tb_scancode_to_uart;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, new_code, tx_busy;
  logic [7:0] scancode;
  logic [7:0] tx_data, last_ascii;
  logic       tx_en, key_strobe, overflow;

  scancode_to_uart #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .scancode   (scancode),
    .new_code   (new_code),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .last_ascii (last_ascii),
    .key_strobe (key_strobe),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Character model: a table of make codes and a queue of accepted characters
  logic [7:0] amap [logic [7:0]];
  logic       m_brk, m_ext, m_ovf;
  logic [7:0] m_last, m_txd;
  logic [7:0] m_q [$];
  logic [7:0] tx_log [$];
  int         tx_cyc [$];
  int         strobe_cnt;
  logic       cap_nc;
  logic [7:0] cap_sc;
  logic       cv, popped;
  logic [7:0] ch;
  int         occ;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    cap_nc <= new_code;
    cap_sc <= scancode;
  end

  always @(negedge clk) begin
    if (reset) begin
      m_brk = 0; m_ext = 0; m_ovf = 0; m_last = 8'h00; m_txd = 8'h00;
      m_q.delete();
      chk("reset tx_en", tx_en, 0);
      chk("reset tx_data", tx_data, 8'h00);
      chk("reset last_ascii", last_ascii, 8'h00);
      chk("reset key_strobe", key_strobe, 0);
      chk("reset overflow", overflow, 0);
    end else begin
      cv = 0;
      ch = 8'h00;
      if (cap_nc) begin
        if (m_ext && m_brk) begin m_ext = 0; m_brk = 0; end
        else if (m_ext) begin if (cap_sc == 8'hF0) m_brk = 1; else m_ext = 0; end
        else if (m_brk) begin if (cap_sc != 8'hF0) m_brk = 0; end
        else if (cap_sc == 8'hF0) m_brk = 1;
        else if (cap_sc == 8'hE0) m_ext = 1;
        else if (amap.exists(cap_sc)) begin cv = 1; ch = amap[cap_sc]; end
      end
      popped = tx_en;
      occ = m_q.size();
      if (popped) begin
        checks++;
        if (occ == 0) begin
          errors++;
          $display("FAIL spurious tx_en: got data %0h expected no send (cycle %0d)", tx_data, cyc);
        end else m_txd = m_q.pop_front();
        tx_log.push_back(tx_data);
        tx_cyc.push_back(cyc);
      end
      chk("tx_data", tx_data, m_txd);
      if (cv) begin
        m_last = ch;
        if (occ < DEPTH || popped) m_q.push_back(ch);
        else m_ovf = 1;
      end
      chk("key_strobe", key_strobe, cv);
      chk("last_ascii", last_ascii, m_last);
      chk("overflow", overflow, m_ovf);
      if (key_strobe) strobe_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output int at);
    @(posedge clk); #1;
    scancode = b; new_code = 1'b1; at = cyc;
    @(posedge clk); #1;
    new_code = 1'b0;
  endtask

  task automatic clear_logs();
    tx_log.delete(); tx_cyc.delete(); strobe_cnt = 0;
  endtask

  task automatic do_reset();
    step(1);
    reset = 1'b1; tx_busy = 1'b0;
    step(2);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic drained(input string nm);
    chk(nm, m_q.size(), 0);
  endtask

  initial begin
    automatic string letters = "abcdefghijklmnopqrstuvwxyz";
    automatic string digits  = "0123456789";
    logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    int t0, t1;
    for (int i = 0; i < 26; i++) amap[lc[i]] = letters[i];
    for (int i = 0; i < 10; i++) amap[dc[i]] = digits[i];
    amap[8'h29] = 8'h20;
    amap[8'h5A] = 8'h0D;
    amap[8'h66] = 8'h08;
    strobe_cnt = 0;

    reset = 1'b1; new_code = 1'b0; scancode = 8'h00; tx_busy = 1'b0;
    step(3);
    reset = 1'b0;
    clear_logs();

    // Press and release 'a'
    send(8'h1C, t0); send(8'hF0, t1); send(8'h1C, t1);
    step(10);
    chk("a sends", tx_log.size(), 1);
    if (tx_log.size() > 0) begin
      chk("a data", tx_log[0], 8'h61);
      chk("a latency", tx_cyc[0] - t0, 2);
    end
    chk("a last_ascii", last_ascii, 8'h61);
    chk("a strobes", strobe_cnt, 1);

    // Extended make/break produces nothing; decoder back in IDLE afterwards
    do_reset();
    send(8'hE0, t0); send(8'h75, t0); send(8'hE0, t0); send(8'hF0, t0); send(8'h75, t0);
    step(10);
    chk("ext sends", tx_log.size(), 0);
    chk("ext strobes", strobe_cnt, 0);
    send(8'h1C, t0);
    step(8);
    chk("post-ext sends", tx_log.size(), 1);
    if (tx_log.size() > 0) chk("post-ext data", tx_log[0], 8'h61);

    // "hello " with transmitter busy overflows the 4-deep FIFO
    do_reset();
    tx_busy = 1'b1;
    send(8'h33, t0); send(8'h24, t0); send(8'h4B, t0); send(8'h4B, t0);
    send(8'h44, t0); send(8'h29, t0);
    step(2);
    chk("hello overflow", overflow, 1);
    chk("hello held", tx_log.size(), 0);
    chk("hello last_ascii", last_ascii, 8'h20);
    tx_busy = 1'b0;
    step(30);
    chk("hello sends", tx_log.size(), 4);
    if (tx_log.size() == 4) begin
      chk("hello 0", tx_log[0], 8'h68);
      chk("hello 1", tx_log[1], 8'h65);
      chk("hello 2", tx_log[2], 8'h6C);
      chk("hello 3", tx_log[3], 8'h6C);
    end
    drained("hello drained");

    // Full FIFO: push of '1' coincides with the first pop
    do_reset();
    tx_busy = 1'b1;
    send(8'h1C, t0); send(8'h32, t0); send(8'h21, t0); send(8'h23, t0);
    step(2);
    chk("full no overflow", overflow, 0);
    tx_busy = 1'b0; scancode = 8'h16; new_code = 1'b1;
    step(1);
    new_code = 1'b0;
    step(30);
    chk("full overflow", overflow, 0);
    chk("full sends", tx_log.size(), 5);
    if (tx_log.size() == 5) begin
      chk("full first", tx_log[0], 8'h61);
      chk("full last", tx_log[4], 8'h31);
    end
    drained("full drained");

    // Reset right after a break prefix
    do_reset();
    send(8'hF0, t0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    clear_logs();
    send(8'h1B, t0);
    step(10);
    chk("rst sends", tx_log.size(), 1);
    if (tx_log.size() > 0) chk("rst data", tx_log[0], 8'h73);
    chk("rst overflow", overflow, 0);

    // Enter, backspace, then an unmapped code
    do_reset();
    send(8'h5A, t0); send(8'h66, t0); send(8'h76, t0);
    step(20);
    chk("ctl sends", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("ctl enter", tx_log[0], 8'h0D);
      chk("ctl bksp", tx_log[1], 8'h08);
      chk("ctl spacing", tx_cyc[1] - tx_cyc[0], 4);
    end
    chk("ctl strobes", strobe_cnt, 2);
    chk("ctl tx_data hold", tx_data, 8'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
